pad_scan_ctl: RTL and testbench

Frame-synchronous sequencer for the two analog paddle one-shots. Once per frame it fires the shared paddle trigger, times how long each PADx_OUT pulse stays high, and hands two 8-bit paddle positions to the paddle/hit logic with a one-cycle valid strobe. It replaces the free-running trigger tie-off with a controlled, timeout-protected measurement sequence.

---
 rtl/pong_pkg.sv | 17 +
 rtl/pad_timer.sv | 46 ++++
 rtl/pad_scan_ctl.sv | 115 +++++++++++
 tb/tb_pad_scan_ctl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle scan sequencer and its per-pad timers.
package pong_pkg;

    typedef enum logic [1:0] {IDLE, TRIG, MEASURE, DONE} pad_scan_state_t;

    localparam int PAD_POS_W = 8;
    localparam logic [PAD_POS_W-1:0] PAD_POS_MAX = 8'd255;

    // Rounded mean of two positions; the 9-bit sum keeps the carry.
    function automatic logic [PAD_POS_W-1:0] pos_avg(input logic [PAD_POS_W-1:0] a,
                                                     input logic [PAD_POS_W-1:0] b);
        logic [PAD_POS_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[PAD_POS_W:1];
    endfunction

endpackage

// File: rtl/pad_timer.sv
// One paddle channel: 2-flop synchronizer, done flag and saturating tick counter.
module pad_timer
    import pong_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 tick,
    input  logic                 pad,
    output logic [PAD_POS_W-1:0] count,
    output logic                 done,
    output logic                 tmo
);

    logic pad_meta;
    logic pad_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_meta <= 1'b0;
            pad_sync <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            pad_meta <= pad;
            pad_sync <= pad_meta;
            if (clear) begin
                count <= '0;
                done  <= 1'b0;
                tmo   <= 1'b0;
            end else if (tick && !done) begin
                // A pad still high after 255 counted ticks is a timeout, not a wrap.
                if (!pad_sync) begin
                    done <= 1'b1;
                end else if (count == PAD_POS_MAX) begin
                    done <= 1'b1;
                    tmo  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pad_scan_ctl.sv
// Once-per-frame paddle trigger and pulse-width measurement sequencer.
// Define PAD_SCAN_AVG_EN to report the rounded mean of the current and previous raw scans.
module pad_scan_ctl
    import pong_pkg::*;
#(
    parameter int TRIG_LEN = 16,
    parameter int TICK_DIV = 64
) (
    input  logic                 CLK,
    input  logic                 FPGA_RESET,
    input  logic                 VBLANK,
    input  logic                 PAD1_OUT,
    input  logic                 PAD2_OUT,
    output logic                 PAD_TRG_N,
    output logic [PAD_POS_W-1:0] PAD1_POS,
    output logic [PAD_POS_W-1:0] PAD2_POS,
    output logic                 POS_VALID,
    output logic                 PAD1_TMO,
    output logic                 PAD2_TMO,
    output pad_scan_state_t      state_dbg
);

    pad_scan_state_t      state;
    logic                 vblank_q;
    logic [9:0]           presc;
    logic [7:0]           trig_cnt;
    logic                 tick;
    logic                 clear;
    logic [PAD_POS_W-1:0] cnt1, cnt2;
    logic                 done1, done2, tmo1, tmo2;

`ifdef PAD_SCAN_AVG_EN
    logic [PAD_POS_W-1:0] raw1_prev, raw2_prev;
`endif

    assign tick      = (state == MEASURE) && (presc == 10'(TICK_DIV - 1));
    assign clear     = (state == TRIG);
    assign state_dbg = state;

    pad_timer u_pad1 (
        .clk(CLK), .rst(FPGA_RESET), .clear(clear), .tick(tick), .pad(PAD1_OUT),
        .count(cnt1), .done(done1), .tmo(tmo1)
    );

    pad_timer u_pad2 (
        .clk(CLK), .rst(FPGA_RESET), .clear(clear), .tick(tick), .pad(PAD2_OUT),
        .count(cnt2), .done(done2), .tmo(tmo2)
    );

    always_ff @(posedge CLK) begin
        if (FPGA_RESET) begin
            state     <= IDLE;
            vblank_q  <= 1'b0;
            presc     <= '0;
            trig_cnt  <= '0;
            PAD_TRG_N <= 1'b1;
            PAD1_POS  <= '0;
            PAD2_POS  <= '0;
            POS_VALID <= 1'b0;
            PAD1_TMO  <= 1'b0;
            PAD2_TMO  <= 1'b0;
`ifdef PAD_SCAN_AVG_EN
            raw1_prev <= '0;
            raw2_prev <= '0;
`endif
        end else begin
            vblank_q  <= VBLANK;
            POS_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (VBLANK && !vblank_q) begin
                        state     <= TRIG;
                        PAD_TRG_N <= 1'b0;
                        trig_cnt  <= '0;
                    end
                end
                TRIG: begin
                    // Timers are held clear for the whole trigger, so MEASURE starts from zero.
                    presc <= '0;
                    if (trig_cnt == 8'(TRIG_LEN - 1)) begin
                        state     <= MEASURE;
                        PAD_TRG_N <= 1'b1;
                    end else begin
                        trig_cnt <= trig_cnt + 8'd1;
                    end
                end
                MEASURE: begin
                    presc <= tick ? '0 : presc + 10'd1;
                    if (done1 && done2) begin
                        state     <= DONE;
                        POS_VALID <= 1'b1;
                        PAD1_TMO  <= tmo1;
                        PAD2_TMO  <= tmo2;
`ifdef PAD_SCAN_AVG_EN
                        PAD1_POS  <= pos_avg(cnt1, raw1_prev);
                        PAD2_POS  <= pos_avg(cnt2, raw2_prev);
                        raw1_prev <= cnt1;
                        raw2_prev <= cnt2;
`else
                        PAD1_POS  <= cnt1;
                        PAD2_POS  <= cnt2;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_scan_ctl.sv
// Directed bench for pad_scan_ctl with TRIG_LEN=2, TICK_DIV=4.
module tb_pad_scan_ctl;
    import pong_pkg::*;

    logic            CLK = 1'b0;
    logic            FPGA_RESET = 1'b1;
    logic            VBLANK = 1'b0;
    logic            PAD1_OUT = 1'b0;
    logic            PAD2_OUT = 1'b0;
    logic            PAD_TRG_N;
    logic [7:0]      PAD1_POS, PAD2_POS;
    logic            POS_VALID, PAD1_TMO, PAD2_TMO;
    pad_scan_state_t state_dbg;

    int checks = 0;
    int passed = 0;
    logic [7:0] prev1 = 8'd0;
    logic [7:0] prev2 = 8'd0;

    pad_scan_ctl #(.TRIG_LEN(2), .TICK_DIV(4)) dut (
        .CLK(CLK), .FPGA_RESET(FPGA_RESET), .VBLANK(VBLANK),
        .PAD1_OUT(PAD1_OUT), .PAD2_OUT(PAD2_OUT), .PAD_TRG_N(PAD_TRG_N),
        .PAD1_POS(PAD1_POS), .PAD2_POS(PAD2_POS), .POS_VALID(POS_VALID),
        .PAD1_TMO(PAD1_TMO), .PAD2_TMO(PAD2_TMO), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_pos(input logic [7:0] raw, input logic [7:0] prev);
`ifdef PAD_SCAN_AVG_EN
        logic [8:0] s;
        s = {1'b0, raw} + {1'b0, prev} + 9'd1;
        return s[8:1];
`else
        return raw;
`endif
    endfunction

    // Runs one scan: a pad with width w reads high on ticks 1..w and low on tick w+1.
    task automatic scan(input int w1, input int w2, input bit retrig,
                        output logic [7:0] p1, output logic [7:0] p2,
                        output logic t1, output logic t2,
                        output int lat, output int trg_low, output int valid_w,
                        output bit ok, output bit trg_bad, output logic trg_pre);
        int t;
        ok = 1'b0; trg_bad = 1'b0; lat = 0; valid_w = 0;
        @(negedge CLK);
        trg_pre = PAD_TRG_N;
        VBLANK = 1'b1; PAD1_OUT = (w1 > 0); PAD2_OUT = (w2 > 0);
        @(negedge CLK);
        VBLANK = 1'b0;
        while (PAD_TRG_N !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        trg_low = lat;
        t = 0;
        while (POS_VALID !== 1'b1 && t < 1500) begin
            @(negedge CLK);
            t++; lat++;
            if (t == 4 * w1 + 1) PAD1_OUT = 1'b0;
            if (t == 4 * w2 + 1) PAD2_OUT = 1'b0;
            VBLANK = (retrig && t == 10);
            if (PAD_TRG_N !== 1'b1) trg_bad = 1'b1;
        end
        VBLANK = 1'b0; PAD1_OUT = 1'b0; PAD2_OUT = 1'b0;
        ok = (POS_VALID === 1'b1);
        p1 = PAD1_POS; p2 = PAD2_POS; t1 = PAD1_TMO; t2 = PAD2_TMO;
        for (int i = 0; i < 3 && POS_VALID === 1'b1; i++) begin
            valid_w++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        FPGA_RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (PAD_TRG_N !== 1'b1) $display("FAIL reset_trg_n: got %b expected 1", PAD_TRG_N); else passed++;
        checks++; if (PAD1_POS !== 8'd0) $display("FAIL reset_pos1: got %0d expected 0", PAD1_POS); else passed++;
        checks++; if (PAD2_POS !== 8'd0) $display("FAIL reset_pos2: got %0d expected 0", PAD2_POS); else passed++;
        checks++; if (POS_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", POS_VALID); else passed++;
        checks++; if (PAD1_TMO !== 1'b0) $display("FAIL reset_tmo1: got %b expected 0", PAD1_TMO); else passed++;
        checks++; if (PAD2_TMO !== 1'b0) $display("FAIL reset_tmo2: got %b expected 0", PAD2_TMO); else passed++;
        checks++; if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); else passed++;
        FPGA_RESET = 1'b0;
        prev1 = 8'd0; prev2 = 8'd0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_normal;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb;
        scan(40, 100, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok) $display("FAIL normal_valid_seen: got 0 expected 1"); else passed++;
        checks++; if (p1 !== exp_pos(8'd40, prev1)) $display("FAIL normal_pos1: got %0d expected %0d", p1, exp_pos(8'd40, prev1)); else passed++;
        checks++; if (p2 !== exp_pos(8'd100, prev2)) $display("FAIL normal_pos2: got %0d expected %0d", p2, exp_pos(8'd100, prev2)); else passed++;
        checks++; if (t1 !== 1'b0 || t2 !== 1'b0) $display("FAIL normal_tmo: got %b%b expected 00", t1, t2); else passed++;
        checks++; if (vw != 1) $display("FAIL normal_valid_width: got %0d expected 1", vw); else passed++;
        prev1 = 8'd40; prev2 = 8'd100;
    endtask

    task automatic test_trigger_shape;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb, extra;
        scan(20, 20, 1'b1, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (tp !== 1'b1) $display("FAIL trig_idle_high: got %b expected 1", tp); else passed++;
        checks++; if (tl != 2) $display("FAIL trig_low_cycles: got %0d expected 2", tl); else passed++;
        checks++; if (tb) $display("FAIL trig_retrigger: got trigger low during MEASURE expected none"); else passed++;
        checks++; if (!ok || p1 !== exp_pos(8'd20, prev1)) $display("FAIL trig_pos1: got %0d expected %0d", p1, exp_pos(8'd20, prev1)); else passed++;
        extra = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (POS_VALID !== 1'b0 || PAD_TRG_N !== 1'b1) extra = 1'b1;
        end
        checks++; if (extra) $display("FAIL trig_no_queued_scan: got activity expected none"); else passed++;
        prev1 = 8'd20; prev2 = 8'd20;
    endtask

    task automatic test_saturation;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb;
        scan(60, 300, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || p2 !== exp_pos(8'd255, prev2)) $display("FAIL sat_pos2: got %0d expected %0d", p2, exp_pos(8'd255, prev2)); else passed++;
        checks++; if (t2 !== 1'b1) $display("FAIL sat_tmo2: got %b expected 1", t2); else passed++;
        checks++; if (p1 !== exp_pos(8'd60, prev1) || t1 !== 1'b0) $display("FAIL sat_pad1: got %0d/%b expected %0d/0", p1, t1, exp_pos(8'd60, prev1)); else passed++;
        prev1 = 8'd60; prev2 = 8'd255;
        scan(30, 10, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || t2 !== 1'b0) $display("FAIL sat_tmo2_clear: got %b expected 0", t2); else passed++;
        checks++; if (p2 !== exp_pos(8'd10, prev2)) $display("FAIL sat_next_pos2: got %0d expected %0d", p2, exp_pos(8'd10, prev2)); else passed++;
        prev1 = 8'd30; prev2 = 8'd10;
    endtask

    task automatic test_zero_width;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb;
        scan(0, 0, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || p1 !== exp_pos(8'd0, prev1)) $display("FAIL zero_pos1: got %0d expected %0d", p1, exp_pos(8'd0, prev1)); else passed++;
        checks++; if (p2 !== exp_pos(8'd0, prev2)) $display("FAIL zero_pos2: got %0d expected %0d", p2, exp_pos(8'd0, prev2)); else passed++;
        checks++; if (t1 !== 1'b0 || t2 !== 1'b0) $display("FAIL zero_tmo: got %b%b expected 00", t1, t2); else passed++;
        checks++; if (lat < 7 || lat > 9) $display("FAIL zero_latency: got %0d expected 7..9", lat); else passed++;
        prev1 = 8'd0; prev2 = 8'd0;
    endtask

    task automatic test_reset_mid_measure;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb, saw;
        @(negedge CLK);
        VBLANK = 1'b1; PAD1_OUT = 1'b1; PAD2_OUT = 1'b1;
        @(negedge CLK);
        VBLANK = 1'b0;
        repeat (20) @(negedge CLK);
        checks++; if (state_dbg !== MEASURE) $display("FAIL midrst_in_measure: got %0d expected %0d", state_dbg, MEASURE); else passed++;
        FPGA_RESET = 1'b1;
        @(negedge CLK);
        checks++; if (state_dbg !== IDLE) $display("FAIL midrst_state: got %0d expected %0d", state_dbg, IDLE); else passed++;
        checks++; if (PAD1_POS !== 8'd0 || PAD2_POS !== 8'd0) $display("FAIL midrst_pos: got %0d/%0d expected 0/0", PAD1_POS, PAD2_POS); else passed++;
        checks++; if (PAD_TRG_N !== 1'b1 || POS_VALID !== 1'b0) $display("FAIL midrst_ctl: got trg_n=%b valid=%b expected 1/0", PAD_TRG_N, POS_VALID); else passed++;
        checks++; if (PAD1_TMO !== 1'b0 || PAD2_TMO !== 1'b0) $display("FAIL midrst_tmo: got %b%b expected 00", PAD1_TMO, PAD2_TMO); else passed++;
        FPGA_RESET = 1'b0;
        prev1 = 8'd0; prev2 = 8'd0;
        saw = 1'b0;
        repeat (60) begin
            @(negedge CLK);
            if (POS_VALID !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw || state_dbg !== IDLE) $display("FAIL midrst_aborted: got valid=%b state=%0d expected 0/%0d", saw, state_dbg, IDLE); else passed++;
        PAD1_OUT = 1'b0; PAD2_OUT = 1'b0;
        repeat (3) @(negedge CLK);
        scan(5, 7, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || p1 !== exp_pos(8'd5, prev1) || p2 !== exp_pos(8'd7, prev2))
            $display("FAIL midrst_clean_scan: got %0d/%0d expected %0d/%0d", p1, p2, exp_pos(8'd5, prev1), exp_pos(8'd7, prev2));
        else passed++;
        prev1 = 8'd5; prev2 = 8'd7;
    endtask

`ifdef PAD_SCAN_AVG_EN
    task automatic test_avg;
        logic [7:0] p1, p2; logic t1, t2, tp; int lat, tl, vw; bit ok, tb;
        test_reset;
        scan(100, 0, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || p1 !== 8'd50) $display("FAIL avg_first: got %0d expected 50", p1); else passed++;
        scan(51, 0, 1'b0, p1, p2, t1, t2, lat, tl, vw, ok, tb, tp);
        checks++; if (!ok || p1 !== 8'd76) $display("FAIL avg_second: got %0d expected 76", p1); else passed++;
        prev1 = 8'd51; prev2 = 8'd0;
    endtask
`endif

    initial begin
        test_reset;
        test_normal;
        test_trigger_shape;
        test_saturation;
        test_zero_width;
        test_reset_mid_measure;
`ifdef PAD_SCAN_AVG_EN
        test_avg;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
